ring_fifo: RTL and testbench
============================

# ring_fifo

Parameterized synchronous circular-buffer FIFO with valid/ready handshakes on both enqueue and dequeue sides, used as the generic queue primitive throughout the core (fetch/issue/ROB-side buffers). Occupancy is tracked by two wrap-extended up-counters. A synchronous `init` port loads the entry array and both counters in one cycle, so benches can start from arbitrary states such as wrapped or near-full.

## Interface
- `N_ENTRIES`, 8: depth; power of two, ≥ 2.
- `ENTRY_WIDTH`, 32: bits per entry.
- `PTR_WIDTH` (localparam), `$clog2(N_ENTRIES)`: index width.
- `CTR_WIDTH` (localparam), `PTR_WIDTH+1`: counter width; the extra MSB disambiguates full from empty.

- `clk` input 1: clock; all state updates on the rising edge.
- `rst_aL` input 1: reset, asynchronous, active-high.
- `enq_ready` output 1: FIFO can accept data.
- `enq_valid` input 1: producer presents `enq_data`.
- `enq_data` input ENTRY_WIDTH: data to enqueue.
- `deq_ready` input 1: consumer accepts the head.
- `deq_valid` output 1: head entry valid.
- `deq_data` output ENTRY_WIDTH: head entry.
- `count` output CTR_WIDTH: occupancy, 0..N_ENTRIES.
- `init` input 1: synchronous state load (with `RING_FIFO_INIT_EN`).
- `init_entry_reg_state` input [N_ENTRIES][ENTRY_WIDTH]: entry array load value.
- `init_enq_up_counter_state` input CTR_WIDTH: enqueue counter load value.
- `init_deq_up_counter_state` input CTR_WIDTH: dequeue counter load value.

## Operation
- State: entry array `entry[N_ENTRIES]`, enqueue counter `E`, dequeue counter `D` (each CTR_WIDTH, wraps mod 2^CTR_WIDTH).
- Pointers: `enq_ptr = E[PTR_WIDTH-1:0]`, `deq_ptr = D[PTR_WIDTH-1:0]`.
- Empty: `E == D`. Full: MSBs differ and pointers are equal.
- Occupancy: `count = (E - D) mod 2^CTR_WIDTH`.
- `enq_ready = !full`, `deq_valid = !empty`, `deq_data = entry[deq_ptr]`; all combinational from state.
- Enqueue fires when `enq_valid && enq_ready`: write `entry[enq_ptr] <= enq_data`, then `E <= E+1`.
- Dequeue fires when `deq_valid && deq_ready`: `D <= D+1`. Entry contents are left unchanged.
- Enqueue and dequeue fire independently in the same cycle, so a simultaneous pair leaves `count` unchanged.
- No bypass paths:
  - Empty FIFO: `deq_valid` stays 0 even if `enq_valid` is high.
  - Full FIFO: `enq_ready` stays 0 even if a dequeue fires that cycle.
- `init` high at an edge loads all three state elements from the `init_*` inputs and overrides any enqueue/dequeue that cycle.
- `init` values are not sanity-checked; any `E`/`D` pair is legal, and the flags and `count` follow the formulas above.
- Overflow/underflow cannot occur through the handshakes.

## Timing
- Reset asserted (asynchronous, active-high): `E=0`, `D=0`, all entries 0.
  - Outputs during reset: `enq_ready=1`, `deq_valid=0`, `count=0`, `deq_data=0`.
- Reset dominates `init` and handshakes.
- Reset asserted mid-operation discards all contents immediately.
- Latency: data enqueued at edge k is visible on `deq_data` with `deq_valid=1` after edge k (1 cycle), provided it is at the head.
- The `init` load takes effect at the next rising edge; outputs reflect the loaded state from that edge onward.

## Configuration
- `RING_FIFO_INIT_EN` defined: the `init*` ports and the load path exist.
- Undefined: those ports and the load path are absent, and state changes only through reset and the handshakes.

## Structure
- Shared package `ring_fifo_pkg`: helper function for `PTR_WIDTH`/`CTR_WIDTH` derivation, plus a flag-computation function.
- One sub-module, `up_counter`:
  - width parameter; ports `clk`, `rst_aL`, `inc`, `load`, `load_val`;
  - holds its value in an internal register instance `counter_reg` with output `dout`.
- Instantiate it twice as `enq_up_counter` and `deq_up_counter`. These hierarchical paths are probed by benches.

## Test plan
- Reset with no traffic: `count=0`, `enq_ready=1`, `deq_valid=0`.
- Init load with entries `0xDEADBEE0+i`, `E=4'b1001`, `D=4'b0110`, `init=1` for one edge:
  - after that edge, `enq_up_counter.counter_reg.dout=9` and `deq_up_counter.counter_reg.dout=6`;
  - `count=3`, `deq_data=0xDEADBEE6`, `enq_ready=1`, `deq_valid=1`.
- Fill from reset: enqueue 1..8 → `count=8`, `enq_ready=0`. A ninth `enq_valid` is ignored. Dequeue yields 1..8 in order, then `deq_valid=0`.
- Wrap-around: init `E=D=4'b0111`, then enqueue/dequeue 4 items → data returned in order and `E`/`D` wrap through index 0.
- Simultaneous enqueue/dequeue at `count=3` → `count` stays 3 and the head advances.
- Reset asserted mid-stream with `count=5` → all outputs return to reset values asynchronously, before the next edge.

Source files
------------

// File: rtl/ring_fifo_pkg.sv
// Shared width helpers and flag computation for ring_fifo and its counters.
package ring_fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
  } flags_t;

  function automatic int unsigned ptr_width_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned ctr_width_of(input int unsigned n);
    return ptr_width_of(n) + 1;
  endfunction

  // occ is (E - D) mod 2^CTR_WIDTH; for a power-of-two depth, occ == n is
  // exactly "MSBs differ and pointers equal".
  function automatic flags_t calc_flags(input logic [31:0] occ, input int unsigned n);
    flags_t f;
    f.full  = (occ == 32'(n));
    f.empty = (occ == '0);
    return f;
  endfunction

endpackage

// File: rtl/ring_fifo_up_counter.sv
// Wrap-around up-counter with synchronous load, built on a plain enable register.
module ring_fifo_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_aL,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or posedge rst_aL) begin
    if (rst_aL)  dout <= '0;
    else if (en) dout <= din;
  end

endmodule

module up_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_aL,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] next_val;

  always_comb begin
    next_val = dout;
    if (load)     next_val = load_val;
    else if (inc) next_val = dout + WIDTH'(1);
  end

  ring_fifo_reg #(.WIDTH(WIDTH)) counter_reg (
    .clk    (clk),
    .rst_aL (rst_aL),
    .en     (load | inc),
    .din    (next_val),
    .dout   (dout)
  );

endmodule

// File: rtl/ring_fifo.sv
// Circular-buffer FIFO with valid/ready on both sides.
// Define RING_FIFO_INIT_EN to add the synchronous init state-load ports.
module ring_fifo
  import ring_fifo_pkg::*;
#(
  parameter  int unsigned N_ENTRIES   = 8,
  parameter  int unsigned ENTRY_WIDTH = 32,
  localparam int unsigned PTR_WIDTH   = ptr_width_of(N_ENTRIES),
  localparam int unsigned CTR_WIDTH   = ctr_width_of(N_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst_aL,
  output logic                   enq_ready,
  input  logic                   enq_valid,
  input  logic [ENTRY_WIDTH-1:0] enq_data,
  input  logic                   deq_ready,
  output logic                   deq_valid,
  output logic [ENTRY_WIDTH-1:0] deq_data,
  output logic [CTR_WIDTH-1:0]   count
`ifdef RING_FIFO_INIT_EN
  ,
  input  logic                                   init,
  input  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]  init_entry_reg_state,
  input  logic [CTR_WIDTH-1:0]                   init_enq_up_counter_state,
  input  logic [CTR_WIDTH-1:0]                   init_deq_up_counter_state
`endif
);

  logic [CTR_WIDTH-1:0]   enq_ctr;
  logic [CTR_WIDTH-1:0]   deq_ctr;
  logic [CTR_WIDTH-1:0]   occ;
  logic [PTR_WIDTH-1:0]   enq_ptr;
  logic [PTR_WIDTH-1:0]   deq_ptr;
  logic [ENTRY_WIDTH-1:0] entry [N_ENTRIES];
  flags_t                 flags;
  logic                   enq_fire;
  logic                   deq_fire;
  logic                   load;
  logic [CTR_WIDTH-1:0]   enq_load_val;
  logic [CTR_WIDTH-1:0]   deq_load_val;

`ifdef RING_FIFO_INIT_EN
  assign load         = init;
  assign enq_load_val = init_enq_up_counter_state;
  assign deq_load_val = init_deq_up_counter_state;
`else
  assign load         = 1'b0;
  assign enq_load_val = '0;
  assign deq_load_val = '0;
`endif

  assign enq_ptr = enq_ctr[PTR_WIDTH-1:0];
  assign deq_ptr = deq_ctr[PTR_WIDTH-1:0];
  assign occ     = enq_ctr - deq_ctr;
  assign flags   = calc_flags(32'(occ), N_ENTRIES);

  assign enq_ready = !flags.full;
  assign deq_valid = !flags.empty;
  assign deq_data  = entry[deq_ptr];
  assign count     = occ;

  assign enq_fire = enq_valid && enq_ready && !load;
  assign deq_fire = deq_valid && deq_ready && !load;

  up_counter #(.WIDTH(CTR_WIDTH)) enq_up_counter (
    .clk      (clk),
    .rst_aL   (rst_aL),
    .inc      (enq_fire),
    .load     (load),
    .load_val (enq_load_val),
    .dout     (enq_ctr)
  );

  up_counter #(.WIDTH(CTR_WIDTH)) deq_up_counter (
    .clk      (clk),
    .rst_aL   (rst_aL),
    .inc      (deq_fire),
    .load     (load),
    .load_val (deq_load_val),
    .dout     (deq_ctr)
  );

  always_ff @(posedge clk or posedge rst_aL) begin
    if (rst_aL) begin
      for (int unsigned i = 0; i < N_ENTRIES; i++) entry[i] <= '0;
    end else begin
`ifdef RING_FIFO_INIT_EN
      if (init) begin
        for (int unsigned i = 0; i < N_ENTRIES; i++) entry[i] <= init_entry_reg_state[i];
      end else if (enq_fire) begin
        entry[enq_ptr] <= enq_data;
      end
`else
      if (enq_fire) entry[enq_ptr] <= enq_data;
`endif
    end
  end

endmodule

// File: tb/tb_ring_fifo.sv
// Directed self-checking bench for ring_fifo (init tests only with RING_FIFO_INIT_EN).
module tb_ring_fifo;

  logic        clk = 1'b0;
  logic        rst_aL;
  logic        enq_ready;
  logic        enq_valid;
  logic [31:0] enq_data;
  logic        deq_ready;
  logic        deq_valid;
  logic [31:0] deq_data;
  logic [3:0]  count;
`ifdef RING_FIFO_INIT_EN
  logic             init;
  logic [7:0][31:0] init_entry_reg_state;
  logic [3:0]       init_enq_up_counter_state;
  logic [3:0]       init_deq_up_counter_state;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  ring_fifo #(.N_ENTRIES(8), .ENTRY_WIDTH(32)) dut (
    .clk       (clk),
    .rst_aL    (rst_aL),
    .enq_ready (enq_ready),
    .enq_valid (enq_valid),
    .enq_data  (enq_data),
    .deq_ready (deq_ready),
    .deq_valid (deq_valid),
    .deq_data  (deq_data),
    .count     (count)
`ifdef RING_FIFO_INIT_EN
    ,
    .init                      (init),
    .init_entry_reg_state      (init_entry_reg_state),
    .init_enq_up_counter_state (init_enq_up_counter_state),
    .init_deq_up_counter_state (init_deq_up_counter_state)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_aL    = 1'b1;
    enq_valid = 1'b0;
    enq_data  = '0;
    deq_ready = 1'b0;
`ifdef RING_FIFO_INIT_EN
    init = 1'b0;
    init_entry_reg_state      = '0;
    init_enq_up_counter_state = '0;
    init_deq_up_counter_state = '0;
`endif
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_enq_ready", 32'(enq_ready), 1);
    check("rst_deq_valid", 32'(deq_valid), 0);
    check("rst_deq_data", deq_data, 0);
    rst_aL = 1'b0;
    tick();

`ifdef RING_FIFO_INIT_EN
    // Init load, with handshakes asserted to confirm init overrides them.
    for (int i = 0; i < 8; i++) init_entry_reg_state[i] = 32'hDEADBEE0 + 32'(i);
    init_enq_up_counter_state = 4'b1001;
    init_deq_up_counter_state = 4'b0110;
    init = 1'b1; enq_valid = 1'b1; enq_data = 32'h1234; deq_ready = 1'b1;
    tick();
    init = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    #1;
    check("init_enq_ctr", 32'(dut.enq_up_counter.counter_reg.dout), 9);
    check("init_deq_ctr", 32'(dut.deq_up_counter.counter_reg.dout), 6);
    check("init_count", 32'(count), 3);
    check("init_deq_data", deq_data, 32'hDEADBEE6);
    check("init_enq_ready", 32'(enq_ready), 1);
    check("init_deq_valid", 32'(deq_valid), 1);

    // Wrap-around: start at E=D=7, entries land at indices 7,0,1,2.
    init_entry_reg_state      = '0;
    init_enq_up_counter_state = 4'b0111;
    init_deq_up_counter_state = 4'b0111;
    init = 1'b1;
    tick();
    init = 1'b0;
    #1;
    check("wrap_empty", 32'(deq_valid), 0);
    for (int i = 0; i < 4; i++) begin
      enq_valid = 1'b1; enq_data = 32'hA0 + 32'(i);
      tick();
    end
    enq_valid = 1'b0;
    #1;
    check("wrap_count", 32'(count), 4);
    check("wrap_enq_ctr", 32'(dut.enq_up_counter.counter_reg.dout), 11);
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("wrap_data%0d", i), deq_data, 32'hA0 + 32'(i));
      tick();
    end
    deq_ready = 1'b0;
    #1;
    check("wrap_deq_ctr", 32'(dut.deq_up_counter.counter_reg.dout), 11);
    check("wrap_drained", 32'(deq_valid), 0);

    rst_aL = 1'b1;
    #2;
    rst_aL = 1'b0;
    tick();
`endif

    // Fill from reset.
    for (int i = 1; i <= 8; i++) begin
      enq_valid = 1'b1; enq_data = 32'(i);
      tick();
    end
    check("fill_count", 32'(count), 8);
    check("fill_enq_ready", 32'(enq_ready), 0);
    check("fill_enq_ctr", 32'(dut.enq_up_counter.counter_reg.dout), 8);
    enq_data = 32'd99;
    tick();
    check("ninth_ignored", 32'(count), 8);

    // Full: a dequeue in the same cycle must not open enq_ready.
    enq_data = 32'd77; deq_ready = 1'b1;
    #1;
    check("full_no_bypass", 32'(enq_ready), 0);
    check("full_head", deq_data, 1);
    tick();
    enq_valid = 1'b0;
    #1;
    check("full_deq_count", 32'(count), 7);
    for (int i = 2; i <= 8; i++) begin
      check($sformatf("drain_valid%0d", i), 32'(deq_valid), 1);
      check($sformatf("drain_data%0d", i), deq_data, 32'(i));
      tick();
    end
    deq_ready = 1'b0;
    #1;
    check("drain_empty", 32'(deq_valid), 0);
    check("drain_count", 32'(count), 0);

    // Empty: no bypass, then one-cycle latency.
    enq_valid = 1'b1; enq_data = 32'd55;
    #1;
    check("empty_no_bypass", 32'(deq_valid), 0);
    tick();
    enq_data = 32'd56;
    check("latency_valid", 32'(deq_valid), 1);
    check("latency_data", deq_data, 55);
    tick();
    enq_data = 32'd57;
    tick();
    check("pre_sim_count", 32'(count), 3);

    // Simultaneous enqueue/dequeue at count 3, then six more pairs so both counters wrap.
    enq_data = 32'd58; deq_ready = 1'b1;
    tick();
    check("sim_count", 32'(count), 3);
    check("sim_head", deq_data, 56);
    for (int i = 0; i < 6; i++) begin
      enq_data = 32'd59 + 32'(i);
      tick();
    end
    deq_ready = 1'b0;
    enq_valid = 1'b0;
    #1;
    check("ctr_wrap_count", 32'(count), 3);
    check("ctr_wrap_head", deq_data, 62);
    check("ctr_wrap_enq", 32'(dut.enq_up_counter.counter_reg.dout), 2);
    check("ctr_wrap_deq", 32'(dut.deq_up_counter.counter_reg.dout), 15);

    // Reset mid-stream at count 5, observed before the next edge.
    enq_valid = 1'b1;
    enq_data  = 32'd65;
    tick();
    enq_data  = 32'd66;
    tick();
    enq_valid = 1'b0;
    check("pre_rst_count", 32'(count), 5);
    #1;
    rst_aL = 1'b1;
    #1;
    check("async_rst_count", 32'(count), 0);
    check("async_rst_enq_ready", 32'(enq_ready), 1);
    check("async_rst_deq_valid", 32'(deq_valid), 0);
    check("async_rst_deq_data", deq_data, 0);
    rst_aL = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
